// File: rtl/cache_pkg.sv
// Shared definitions for the cache subsystem: arbiter state encoding,
// default bus widths and a width helper.
package cache_pkg;

    localparam int CACHE_ADDR_W = 32;
    localparam int CACHE_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Index width for n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin selector: picks the first pending index after last_grant_i,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_select
    import cache_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic [IDW-1:0]     winner_o,
    output logic               any_valid_o
);

    int idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        // Offset NUM_REQ lands back on last_grant_i, so it wins only when alone.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_REQ;
            if (!any_valid_o && pending_i[IDW'(idx)]) begin
                winner_o    = IDW'(idx);
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one external memory port between NUM_REQ cache controllers with
// round-robin grants, held until memory completes or the watchdog fires.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int  NUM_REQ        = 2,
    parameter int  ADDR_W         = CACHE_ADDR_W,
    parameter int  DATA_W         = CACHE_DATA_W,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int GID_W          = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_error,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [GID_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

    arb_state_e         state_q, state_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pending;
    logic [GID_W-1:0]   winner;
    logic               any_pending;
    logic               done_ok;
    logic               done_err;

    assign pending = req_read | req_write;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (GID_W)
    ) u_rr_select (
        .pending_i    (pending),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_valid_o  (any_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            grant_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        done_ok      = 1'b0;
        done_err     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_pending) begin
                    // Write-back goes first; a held read re-arbitrates afterwards.
                    wr_d         = req_write[winner];
                    rd_d         = ~req_write[winner];
                    addr_d       = req_address[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d      = req_wdata[int'(winner)*DATA_W +: DATA_W];
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                    state_d      = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    done_ok = 1'b1;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done_err = 1'b1;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pulse
        assign req_ready[gi] = done_ok  && (grant_q == GID_W'(gi));
        assign req_error[gi] = done_err && (grant_q == GID_W'(gi));
    end

    assign req_rdata   = (done_ok && rd_q) ? mem_rdata : '0;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: expected completions are queued at
// stimulus time and a negedge monitor pops and compares each pulse.
module tb_cache_mem_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_read, req_write, req_ready, req_error;
    logic [NR*AW-1:0] req_address;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]  req_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]  mem_address;
    logic           mem_read, mem_write, mem_ready, busy;
    logic [0:0]     grant_id;

    typedef struct packed {
        logic [NR-1:0] rdy;
        logic [NR-1:0] err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   lat = 0;
    int   bcnt = 0;
    logic force_rdy = 1'b0;

    cache_mem_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_error(req_error), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: answers on the lat-th BUSY cycle (lat=0 never answers).
    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= 0;
        else     bcnt <= busy ? bcnt + 1 : 0;
    end
    assign mem_ready = force_rdy | (busy && (lat != 0) && (bcnt + 1 == lat));
    assign mem_rdata = (mem_address == 32'h0000_1000) ? 32'hDEAD_BEEF : ~mem_address;

    always @(negedge clk) begin
        if (!rst && ((req_ready | req_error) != '0)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: ready=%b error=%b, required no pulse", req_ready, req_error);
            end else begin
                mon_e = sb_q.pop_front();
                if (req_ready !== mon_e.rdy || req_error !== mon_e.err || req_rdata !== mon_e.rdata) begin
                    bad++;
                    $display("FAIL sb_pulse: got ready=%b error=%b rdata=%h, required ready=%b error=%b rdata=%h",
                             req_ready, req_error, req_rdata, mon_e.rdy, mon_e.err, mon_e.rdata);
                end else begin
                    $display("txn t=%0t ready=%b error=%b rdata=%h grant=%0d", $time, req_ready, req_error, req_rdata, grant_id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [NR-1:0] rdy, input logic [NR-1:0] err, input logic [DW-1:0] rdata);
        exp_t e;
        e.rdy = rdy;
        e.err = err;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_read = '0;
        req_write = '0;
        req_address = '0;
        req_wdata = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_strobes", 64'({mem_read, mem_write}), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_pulses", 64'({req_ready, req_error}), 64'd0);
        rst = 1'b0;

        // Single read with three BUSY cycles
        lat = 3;
        req_address[31:0] = 32'h0000_1000;
        req_read = 2'b01;
        push(2'b01, 2'b00, 32'hDEAD_BEEF);
        check("t1_c0_mem_read", 64'(mem_read), 64'd0);
        tick();
        check("t1_c1_mem_read", 64'(mem_read), 64'd1);
        check("t1_c1_address", 64'(mem_address), 64'h1000);
        check("t1_c1_grant", 64'(grant_id), 64'd0);
        tick();
        check("t1_c2_mem_read", 64'(mem_read), 64'd1);
        check("t1_c2_ready", 64'(req_ready), 64'd0);
        tick();
        check("t1_c3_ready", 64'(req_ready), 64'b01);
        check("t1_c3_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
        tick();
        check("t1_c4_busy", 64'(busy), 64'd0);
        check("t1_c4_mem_read", 64'(mem_read), 64'd0);
        req_read = '0;

        // Contention: both read continuously, immediate memory response
        do_reset();
        lat = 1;
        req_address = {32'h0000_0200, 32'h0000_0100};
        req_read = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push(2'b01, 2'b00, 32'hFFFF_FEFF);
            else            push(2'b10, 2'b00, 32'hFFFF_FDFF);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2_grant_%0d", k), 64'(grant_id), 64'(k % 2));
            check($sformatf("t2_busy_%0d", k), 64'(busy), 64'd1);
            check($sformatf("t2_ready_%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            check($sformatf("t2_gap_%0d", k), 64'({busy, mem_read}), 64'd0);
        end
        req_read = '0;

        // Same requester reads and writes: write first, then read
        lat = 2;
        req_address[63:32] = 32'h0000_2000;
        req_wdata[63:32] = 32'h1234_5678;
        req_read = 2'b10;
        req_write = 2'b10;
        push(2'b10, 2'b00, 32'h0000_0000);
        push(2'b10, 2'b00, 32'hFFFF_DFFF);
        tick();
        check("t3_c1_strobes", 64'({mem_read, mem_write}), 64'b01);
        check("t3_c1_wdata", 64'(mem_wdata), 64'h1234_5678);
        check("t3_c1_address", 64'(mem_address), 64'h2000);
        tick();
        check("t3_c2_ready", 64'(req_ready), 64'b10);
        tick();
        check("t3_c3_idle", 64'({busy, mem_read, mem_write}), 64'd0);
        req_write = '0;
        tick();
        check("t3_c4_strobes", 64'({mem_read, mem_write}), 64'b10);
        check("t3_c4_grant", 64'(grant_id), 64'd1);
        tick();
        check("t3_c5_ready", 64'(req_ready), 64'b10);
        tick();
        req_read = '0;
        check("t3_c6_busy", 64'(busy), 64'd0);

        // Timeout with no memory response, then response on the last cycle
        do_reset();
        lat = 0;
        req_address[63:32] = 32'h0000_3000;
        req_read = 2'b10;
        push(2'b00, 2'b10, 32'h0000_0000);
        repeat (7) tick();
        check("t4_c7_busy", 64'(busy), 64'd1);
        check("t4_c7_error", 64'(req_error), 64'd0);
        tick();
        check("t4_c8_error", 64'(req_error), 64'b10);
        check("t4_c8_ready", 64'(req_ready), 64'd0);
        tick();
        check("t4_c9_idle", 64'({busy, mem_read}), 64'd0);
        req_read = '0;
        lat = 8;
        req_address[31:0] = 32'h0000_4000;
        req_read = 2'b01;
        push(2'b01, 2'b00, 32'hFFFF_BFFF);
        repeat (8) tick();
        check("t4b_c8_ready", 64'(req_ready), 64'b01);
        check("t4b_c8_error", 64'(req_error), 64'd0);
        tick();
        req_read = '0;
        check("t4b_c9_busy", 64'(busy), 64'd0);

        // Reset in BUSY cycle 2 abandons the transfer
        lat = 0;
        req_address = {32'h0000_7000, 32'h0000_6000};
        req_read = 2'b10;
        tick();
        check("t5_c1_grant", 64'(grant_id), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_outputs", 64'({busy, mem_read, mem_write, req_ready, req_error}), 64'd0);
        check("t5_rst_grant", 64'(grant_id), 64'd0);
        check("t5_rst_address", 64'(mem_address), 64'd0);
        req_read = 2'b11;
        lat = 1;
        push(2'b01, 2'b00, 32'hFFFF_9FFF);
        push(2'b10, 2'b00, 32'hFFFF_8FFF);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t5_first_grant", 64'(grant_id), 64'd0);
        check("t5_first_ready", 64'(req_ready), 64'b01);
        tick();
        req_read = 2'b10;
        tick();
        check("t5_second_grant", 64'(grant_id), 64'd1);
        tick();
        req_read = '0;

        // Request withdrawn during BUSY still completes
        lat = 3;
        req_address[31:0] = 32'h0000_5000;
        req_read = 2'b01;
        push(2'b01, 2'b00, 32'hFFFF_AFFF);
        tick();
        check("t6_c1_mem_read", 64'(mem_read), 64'd1);
        req_read = '0;
        tick();
        check("t6_c2_mem_read", 64'(mem_read), 64'd1);
        tick();
        check("t6_c3_ready", 64'(req_ready), 64'b01);
        tick();
        check("t6_c4_idle", 64'({busy, mem_read}), 64'd0);

        // mem_ready while IDLE has no effect
        force_rdy = 1'b1;
        tick();
        check("t7_idle_ready_busy", 64'(busy), 64'd0);
        check("t7_idle_ready_pulse", 64'({req_ready, req_error}), 64'd0);
        force_rdy = 1'b0;
        repeat (3) tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
